// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, picks sequential/branch/jump next PC, registers ROM data into IF/ID.
// One-cycle fetch latency; stall freezes PC and IF/ID, and redirects squash the in-flight fetch.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT  = 32'h0000_0100,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_pc_plus4,
  input  logic [15:0] br_offset,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  input  logic [31:0] i_out,
  output logic [31:0] pc_addr,
  output logic        cs_rom,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_base;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        in_range;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_base   = br_pc_plus4 & ~32'h0000_0003;
  assign br_target = br_base + {{14{br_offset[15]}}, br_offset, 2'b00};
  assign j_target  = {br_pc_plus4[31:28], jump_index, 2'b00};
  assign in_range  = (pc_q < PC_LIMIT);

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (!stall) begin
      if (br_taken || jump_en) begin
        // branch beats jump if decode ever asserts both
        pc_d    = br_taken ? br_target : j_target;
        instr_d = NOP_INSTR;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
      end else begin
        pc_d    = pc_plus4;
        pc4_d   = pc_plus4;
        instr_d = in_range ? i_out : NOP_INSTR;
        valid_d = in_range;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign pc_addr        = pc_q;
  assign cs_rom         = !rst && in_range;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;

endmodule
